game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Top-level timing and sequencing controller for the Flappy Bird playfield. It owns the game state (idle/run/over) and derives the `sel` step strobe that gates the collision/score checker. It also issues the bird-motion and pipe-scroll/spawn strobes for the bird and pipe shifters, generates pseudo-random pipe gap rows, and speeds the game up as score accumulates.

Parameters:
TICK_W, 26, width of tick prescaler counter
BASE_PERIOD, 12_500_000, clk cycles per game tick at level 0 (0.25 s @ 50 MHz)
MIN_PERIOD, 3_125_000, floor for tick period
SPEED_STEP, 1_250_000, period reduction per level
SCORE_PER_LEVEL, 5, score pulses per level-up
PIPE_DIV, 2, game ticks per pipe column shift
SPAWN_GAP, 6, pipe shifts between pipe spawns
FLAP_HOLD, 2, bird ticks of upward motion per flap
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
flap  in  1  one-cycle debounced button pulse
gameover  in  1  level from collision checker
score  in  1  one-cycle pulse from collision checker
startGame  out  1  high while in RUN
sel  out  1  one-cycle game tick, drives checker step enable
bird_step  out  1  one-cycle bird move strobe (equals sel)
bird_up  out  1  direction for bird_step: 1 up, 0 down
pipe_shift  out  1  one-cycle pipe column shift strobe
pipe_spawn  out  1  one-cycle, coincident with pipe_shift, inject new pipe
gap_row  out  4  top row of 3-row gap, valid with pipe_spawn, range 1..12
level  out  4  speed level, saturates at 15
game_state  out  2  0 IDLE, 1 RUN, 2 OVER

Behaviour:
- All outputs registered. Reset (async): state IDLE; all strobes, startGame, bird_up and level = 0; gap_row = 0; period = BASE_PERIOD; all counters = 0; LFSR = LFSR_SEED.
- IDLE: prescaler held at 0. LFSR advances every clk. flap -> RUN next cycle, with startGame = 1 and prescaler cleared.
- RUN:
  - Prescaler counts each clk. When count >= period-1 it wraps to 0 and sel/bird_step pulse the next cycle.
  - First sel is exactly BASE_PERIOD cycles after startGame rises; later sels are every period cycles.
  - Using >= lets a period shrink mid-count without overrun.
- Pipe scheduling:
  - Tick counter mod PIPE_DIV: pipe_shift on every PIPE_DIV-th sel, same cycle as that sel.
  - Shift counter mod SPAWN_GAP: pipe_spawn on every SPAWN_GAP-th pipe_shift.
- gap_row: latched from LFSR[3:0] on a spawn.
  - Value 0 becomes 1; values 13..15 become value-4; all others pass unchanged.
  - Holds between spawns.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shift left, feedback into bit 0. Advances every clk in IDLE and RUN, frozen in OVER.
- Flap in RUN: loads rise counter = FLAP_HOLD; bird_up = (rise != 0).
  - Rise counter decrements on each bird_step.
  - flap in the same cycle as the tick wrap: load wins, no decrement.
- Score/speed:
  - Each score pulse increments the score counter mod SCORE_PER_LEVEL.
  - On wrap: level += 1 (saturating) and period = max(period - SPEED_STEP, MIN_PERIOD). Subtraction is done in TICK_W+1 bits so it cannot underflow.
  - New period applies to the current count.
  - score in OVER is ignored.
- gameover sampled high in RUN -> OVER next cycle. No strobe is issued from that cycle on; a wrap in the same cycle is suppressed.
- OVER: startGame = 0, all strobes 0, bird_up = 0; flap and score ignored. Terminal until reset.
- gameover in IDLE is ignored.
- Reset mid-RUN returns to IDLE immediately; any pending strobe is dropped.

Decomposition:
- Package flappy_pkg: game_state_t enum (IDLE, RUN, OVER), LFSR tap mask, GAP_ROWS = 3, MAX_GAP_ROW = 12.
- Sub-module tick_prescaler: programmable-period counter with clear, enable and period input; outputs a registered wrap pulse.

Test Plan:
Bench parameters: BASE_PERIOD=8, MIN_PERIOD=4, SPEED_STEP=2, SCORE_PER_LEVEL=2, PIPE_DIV=2, SPAWN_GAP=3, FLAP_HOLD=2.
1. Reset; flap at cycle 10 -> game_state=1 and startGame=1 at 11. sel at 19, 27, 35, 43. pipe_shift at 27, 43. First pipe_spawn at 3rd shift (cycle 59).
2. Spawn with forced LFSR[3:0] of 0, 5, 13 and 15 -> gap_row 1, 5, 9, 11 respectively.
3. Flap in RUN -> bird_up=1 for the next 2 bird_steps, then 0. Flap on the sel cycle -> 2 full rising steps.
4. 2 score pulses -> level=1, sel spacing 6. After 4 more pulses -> spacing 4 with level=3; later pulses -> spacing stays 4, level keeps rising.
5. gameover asserted in the cycle the prescaler wraps -> no sel that cycle or after; game_state=2, startGame=0. Flap and score ignored; LFSR frozen.
6. Async reset asserted mid-RUN, away from a clk edge -> outputs immediately return to reset values, game_state=0, period restored to 8.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared game-state type, LFSR taps and gap-row folding for the
// Flappy Bird playfield sequencer.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int GAP_ROWS    = 3;
  localparam int MAX_GAP_ROW = 15 - GAP_ROWS;

  function automatic logic [3:0] fold_gap(input logic [3:0] r);
    if (r == 4'd0) return 4'd1;
    if (r > 4'(MAX_GAP_ROW)) return r - 4'(16 - MAX_GAP_ROW);
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Programmable-period tick counter: due flags the wrap about to
// happen, wrap is the registered one-cycle pulse that follows.
module tick_prescaler #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         due,
  output logic         wrap
);

  logic [W-1:0] cnt;

  // >= so a period shrinking below the running count wraps at once
  assign due = en && (cnt >= period - W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (due) begin
      cnt  <= '0;
      wrap <= 1'b1;
    end else begin
      cnt  <= en ? cnt + W'(1) : cnt;
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game state, tick/pipe/bird strobes, gap-row generation and
// score-driven speed-up for the Flappy Bird playfield.
module game_sequencer
  import flappy_pkg::*;
#(
  parameter int          TICK_W          = 26,
  parameter int          BASE_PERIOD     = 12_500_000,
  parameter int          MIN_PERIOD      = 3_125_000,
  parameter int          SPEED_STEP      = 1_250_000,
  parameter int          SCORE_PER_LEVEL = 5,
  parameter int          PIPE_DIV        = 2,
  parameter int          SPAWN_GAP       = 6,
  parameter int          FLAP_HOLD       = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flap,
  input  logic       gameover,
  input  logic       score,
  output logic       startGame,
  output logic       sel,
  output logic       bird_step,
  output logic       bird_up,
  output logic       pipe_shift,
  output logic       pipe_spawn,
  output logic [3:0] gap_row,
  output logic [3:0] level,
  output logic [1:0] game_state
);

  localparam int PW = TICK_W + 1;

  game_state_t       state;
  logic [TICK_W-1:0] period;
  logic [TICK_W-1:0] faster;
  logic [PW-1:0]     diff;
  logic [15:0]       lfsr;
  logic [7:0]        tick_cnt;
  logic [7:0]        shift_cnt;
  logic [7:0]        score_cnt;
  logic [3:0]        rise;
  logic              run;
  logic              due;
  logic              wrap;

  assign run        = (state == RUN);
  assign sel        = wrap;
  assign bird_step  = wrap;
  assign game_state = state;

  // Extra top bit catches underflow before clamping to the floor
  assign diff   = {1'b0, period} - PW'(SPEED_STEP);
  assign faster = (diff[TICK_W] || diff < PW'(MIN_PERIOD))
                ? TICK_W'(MIN_PERIOD) : diff[TICK_W-1:0];

  tick_prescaler #(.W(TICK_W)) u_tick (
    .clk    (clk),
    .rst    (reset),
    .clr    (!run),
    .en     (run && !gameover),
    .period (period),
    .due    (due),
    .wrap   (wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      startGame  <= 1'b0;
      bird_up    <= 1'b0;
      pipe_shift <= 1'b0;
      pipe_spawn <= 1'b0;
      gap_row    <= 4'd0;
      level      <= 4'd0;
      period     <= TICK_W'(BASE_PERIOD);
      lfsr       <= LFSR_SEED;
      tick_cnt   <= 8'd0;
      shift_cnt  <= 8'd0;
      score_cnt  <= 8'd0;
      rise       <= 4'd0;
    end else begin
      pipe_shift <= 1'b0;
      pipe_spawn <= 1'b0;
      if (state != OVER)
        lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      unique case (state)
        IDLE: begin
          if (flap) begin
            state     <= RUN;
            startGame <= 1'b1;
          end
        end
        RUN: begin
          if (gameover) begin
            state     <= OVER;
            startGame <= 1'b0;
            bird_up   <= 1'b0;
          end else begin
            if (due) begin
              if (tick_cnt == 8'(PIPE_DIV - 1)) begin
                tick_cnt   <= 8'd0;
                pipe_shift <= 1'b1;
                if (shift_cnt == 8'(SPAWN_GAP - 1)) begin
                  shift_cnt  <= 8'd0;
                  pipe_spawn <= 1'b1;
                  gap_row    <= fold_gap(lfsr[3:0]);
                end else begin
                  shift_cnt <= shift_cnt + 8'd1;
                end
              end else begin
                tick_cnt <= tick_cnt + 8'd1;
              end
            end
            // A flap landing on the wrap reloads instead of counting down
            if (flap) begin
              rise    <= 4'(FLAP_HOLD);
              bird_up <= (FLAP_HOLD != 0);
            end else begin
              bird_up <= (rise != 4'd0);
              if (due && rise != 4'd0)
                rise <= rise - 4'd1;
            end
            if (score) begin
              if (score_cnt == 8'(SCORE_PER_LEVEL - 1)) begin
                score_cnt <= 8'd0;
                period    <= faster;
                if (level != 4'hF)
                  level <= level + 4'd1;
              end else begin
                score_cnt <= score_cnt + 8'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: vector tables for the
// tick/pipe/bird/speed timelines plus forced-LFSR and reset cases.
module tb_game_sequencer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flap = 1'b0;
  logic       gameover = 1'b0;
  logic       score = 1'b0;
  logic       startGame;
  logic       sel;
  logic       bird_step;
  logic       bird_up;
  logic       pipe_shift;
  logic       pipe_spawn;
  logic [3:0] gap_row;
  logic [3:0] level;
  logic [1:0] game_state;

  int         cyc = 0;
  int         checks = 0;
  int         passed = 0;
  logic [15:0] frc;

  typedef struct {
    int cyc;
    bit fl;
    bit sc;
    bit go;
    int st;
    int start;
    int sel;
    int shift;
    int spawn;
    int up;
    int lvl;
    int gap;
  } vec_t;

  vec_t tv[$];

  always #5 clk = ~clk;

  game_sequencer #(
    .TICK_W          (26),
    .BASE_PERIOD     (8),
    .MIN_PERIOD      (4),
    .SPEED_STEP      (2),
    .SCORE_PER_LEVEL (2),
    .PIPE_DIV        (2),
    .SPAWN_GAP       (3),
    .FLAP_HOLD       (2),
    .LFSR_SEED       (SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flap       (flap),
    .gameover   (gameover),
    .score      (score),
    .startGame  (startGame),
    .sel        (sel),
    .bird_step  (bird_step),
    .bird_up    (bird_up),
    .pipe_shift (pipe_shift),
    .pipe_spawn (pipe_spawn),
    .gap_row    (gap_row),
    .level      (level),
    .game_state (game_state)
  );

  function automatic logic [15:0] adv(logic [15:0] s, int n);
    for (int i = 0; i < n; i++)
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  function automatic int fold(logic [3:0] r);
    if (r == 0) return 1;
    if (r >= 13) return int'(r) - 4;
    return int'(r);
  endfunction

  task automatic chk(string name, int act, int exp);
    if (exp < 0) return;
    checks++;
    if (act != exp)
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               name, cyc, act, exp);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to(int c);
    if (cyc > c) begin
      checks++;
      $display("FAIL order cyc=%0d got=%0d want=%0d", cyc, cyc, c);
    end
    while (cyc < c) tick();
  endtask

  task automatic run_table();
    logic [15:0] m;
    int g;
    foreach (tv[i]) begin
      run_to(tv[i].cyc);
      chk("state", int'(game_state), tv[i].st);
      chk("start", int'(startGame), tv[i].start);
      chk("sel", int'(sel), tv[i].sel);
      chk("bird_step", int'(bird_step), tv[i].sel);
      chk("pipe_shift", int'(pipe_shift), tv[i].shift);
      chk("pipe_spawn", int'(pipe_spawn), tv[i].spawn);
      chk("bird_up", int'(bird_up), tv[i].up);
      chk("level", int'(level), tv[i].lvl);
      g = tv[i].gap;
      if (g == -2) begin
        m = adv(SEED, cyc - 1);
        g = fold(m[3:0]);
      end
      chk("gap_row", int'(gap_row), g);
      flap     = tv[i].fl;
      score    = tv[i].sc;
      gameover = tv[i].go;
      tick();
      flap     = 1'b0;
      score    = 1'b0;
      gameover = 1'b0;
    end
    tv.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [3:0] nibs [4];
    int         exps [4];
    int         sp   [4];
    nibs = '{4'd0, 4'd5, 4'd13, 4'd15};
    exps = '{1, 5, 9, 11};
    sp   = '{107, 155, 203, 251};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;

    // start-up, tick spacing, pipe cadence
    tv.push_back('{0, 0,0,0, 0,0,0,0,0,0,0,0});
    tv.push_back('{5, 0,0,1, 0,0,0,-1,-1,-1,-1,-1});
    tv.push_back('{6, 0,0,0, 0,0,0,-1,-1,-1,-1,-1});
    tv.push_back('{10,1,0,0, 0,0,0,-1,-1,-1,-1,-1});
    tv.push_back('{11,0,0,0, 1,1,0,0,0,0,0,0});
    tv.push_back('{18,0,0,0, 1,1,0,0,0,-1,-1,-1});
    tv.push_back('{19,0,0,0, 1,1,1,0,0,-1,-1,-1});
    tv.push_back('{20,0,0,0, 1,1,0,0,0,-1,-1,-1});
    tv.push_back('{27,0,0,0, 1,1,1,1,0,-1,-1,-1});
    tv.push_back('{35,0,0,0, 1,1,1,0,0,-1,-1,-1});
    tv.push_back('{43,0,0,0, 1,1,1,1,0,-1,-1,0});
    tv.push_back('{51,0,0,0, 1,1,1,0,0,-1,-1,-1});
    tv.push_back('{59,0,0,0, 1,1,1,1,1,-1,-1,-2});
    tv.push_back('{60,0,0,0, 1,1,0,0,0,-1,-1,-1});
    run_table();

    // gap folding with the LFSR pinned
    for (int i = 0; i < 4; i++) begin
      run_to(sp[i] - 1);
      frc = {12'h5A5, nibs[i]};
      force dut.lfsr = frc;
      tick();
      release dut.lfsr;
      chk("spawn_forced", int'(pipe_spawn), 1);
      chk("gap_forced", int'(gap_row), exps[i]);
    end

    // flap hold, including a flap on the sel cycle
    tv.push_back('{254,1,0,0, 1,1,-1,-1,-1,-1,0,11});
    tv.push_back('{255,0,0,0, 1,1,0,-1,-1,1,0,11});
    tv.push_back('{259,0,0,0, 1,1,1,-1,-1,1,-1,-1});
    tv.push_back('{267,0,0,0, 1,1,1,-1,-1,1,-1,-1});
    tv.push_back('{275,0,0,0, 1,1,1,-1,-1,0,-1,-1});
    tv.push_back('{283,1,0,0, 1,1,1,-1,-1,0,-1,-1});
    tv.push_back('{291,0,0,0, 1,1,1,-1,-1,1,-1,-1});
    tv.push_back('{299,0,0,0, 1,1,1,-1,-1,1,-1,-1});
    tv.push_back('{307,0,0,0, 1,1,1,-1,-1,0,0,-1});
    // score-driven speed-up
    tv.push_back('{310,0,1,0, -1,-1,-1,-1,-1,-1,0,-1});
    tv.push_back('{312,0,1,0, -1,-1,0,-1,-1,-1,0,-1});
    tv.push_back('{313,0,0,0, 1,-1,0,-1,-1,-1,1,-1});
    tv.push_back('{314,0,0,0, -1,-1,1,-1,-1,-1,1,-1});
    tv.push_back('{319,0,0,0, -1,-1,0,-1,-1,-1,-1,-1});
    tv.push_back('{320,0,0,0, -1,-1,1,-1,-1,-1,1,-1});
    tv.push_back('{325,0,0,0, -1,-1,0,-1,-1,-1,-1,-1});
    tv.push_back('{326,0,0,0, -1,-1,1,-1,-1,-1,-1,-1});
    tv.push_back('{330,0,1,0, -1,-1,-1,-1,-1,-1,-1,-1});
    tv.push_back('{331,0,0,0, -1,-1,0,-1,-1,-1,-1,-1});
    tv.push_back('{332,0,1,0, -1,-1,1,-1,-1,-1,1,-1});
    tv.push_back('{333,0,0,0, -1,-1,-1,-1,-1,-1,2,-1});
    tv.push_back('{334,0,1,0, -1,-1,-1,-1,-1,-1,-1,-1});
    tv.push_back('{336,0,1,0, -1,-1,1,-1,-1,-1,-1,-1});
    tv.push_back('{337,0,0,0, -1,-1,-1,-1,-1,-1,3,-1});
    tv.push_back('{339,0,0,0, -1,-1,0,-1,-1,-1,-1,-1});
    tv.push_back('{340,0,0,0, -1,-1,1,-1,-1,-1,3,-1});
    tv.push_back('{343,0,0,0, -1,-1,0,-1,-1,-1,-1,-1});
    tv.push_back('{344,0,0,0, -1,-1,1,-1,-1,-1,3,-1});
    tv.push_back('{348,0,0,0, -1,-1,1,-1,-1,-1,-1,-1});
    tv.push_back('{350,0,1,0, -1,-1,-1,-1,-1,-1,-1,-1});
    tv.push_back('{352,0,1,0, -1,-1,1,-1,-1,-1,-1,-1});
    tv.push_back('{353,0,0,0, -1,-1,-1,-1,-1,-1,4,-1});
    tv.push_back('{356,0,0,0, 1,1,1,-1,-1,-1,4,-1});
    run_table();

    // async reset between edges while sel is high
    run_to(360);
    chk("sel_pre_reset", int'(sel), 1);
    reset = 1'b1;
    #1;
    chk("rst_state", int'(game_state), 0);
    chk("rst_start", int'(startGame), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_step", int'(bird_step), 0);
    chk("rst_up", int'(bird_up), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_gap", int'(gap_row), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;

    // restart at base period, then gameover on the wrap cycle
    tv.push_back('{10,1,0,0, 0,0,0,-1,-1,-1,-1,-1});
    tv.push_back('{11,0,0,0, 1,1,0,0,0,0,0,0});
    tv.push_back('{18,0,0,0, 1,1,0,-1,-1,-1,-1,-1});
    tv.push_back('{19,0,0,0, 1,1,1,0,0,-1,-1,-1});
    tv.push_back('{27,0,0,0, 1,1,1,1,0,-1,-1,-1});
    tv.push_back('{35,0,0,0, 1,1,1,0,0,-1,-1,-1});
    tv.push_back('{42,0,0,1, 1,1,0,0,0,-1,-1,-1});
    tv.push_back('{43,0,0,0, 2,0,0,0,0,0,0,-1});
    tv.push_back('{45,1,1,0, 2,0,0,0,0,0,0,-1});
    tv.push_back('{46,0,0,0, 2,0,0,0,0,0,0,-1});
    tv.push_back('{47,0,1,0, 2,0,0,0,0,0,0,-1});
    tv.push_back('{49,0,1,0, 2,0,0,0,0,0,0,-1});
    tv.push_back('{50,0,0,0, 2,0,0,0,0,0,0,-1});
    tv.push_back('{51,0,0,0, 2,0,0,0,0,0,0,-1});
    run_table();

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("over_sel", int'(sel), 0);
      chk("over_shift", int'(pipe_shift), 0);
    end
    chk("lfsr_frozen", int'(dut.lfsr), int'(adv(SEED, 43)));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
